// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port register file with write-through bypass, an optional hard-wired
//   zero register and a per-register pending-write scoreboard for RAW hazard
//   detection in decode.
//
//   Ports:
//     clk, arst_n               clock (rising edge), async active-low reset
//     we_0/waddr_0/wdata_0      write-back lane 0
//     we_1/waddr_1/wdata_1      write-back lane 1 (younger, wins conflicts)
//     raddr  [N_RD*ADDR_W]      read addresses, port k at [k*ADDR_W +: ADDR_W]
//     rdata  [N_RD*DATA_W]      read data (combinational), port k at [k*DATA_W +: DATA_W]
//     rbusy  [N_RD]             port k target pending and not written this cycle
//     rsv_en/rsv_addr           reserve (mark pending) a register
//     pend_cnt [ADDR_W+1]       registered count of pending registers

// One combinational read port: bypass mux plus hazard flag.
module register_file_mp_rd_port #(
    parameter int DATA_W   = 16,
    parameter int N_REG    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [N_REG-1:0][DATA_W-1:0] regs,
    input  logic [N_REG-1:0]             pend,
    input  logic [ADDR_W-1:0]            raddr,
    input  logic                         we_0,
    input  logic [ADDR_W-1:0]            waddr_0,
    input  logic [DATA_W-1:0]            wdata_0,
    input  logic                         we_1,
    input  logic [ADDR_W-1:0]            waddr_1,
    input  logic [DATA_W-1:0]            wdata_1,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rbusy
);
    logic is_zero, hit_0, hit_1;

    assign is_zero = (ZERO_REG != 0) && (raddr == '0);
    assign hit_0   = we_0 && (waddr_0 == raddr);
    assign hit_1   = we_1 && (waddr_1 == raddr);

    // Lane 1 is younger, so it takes priority over lane 0 in the bypass.
    always_comb begin
        if (is_zero)    rdata = '0;
        else if (hit_1) rdata = wdata_1;
        else if (hit_0) rdata = wdata_0;
        else            rdata = regs[raddr];
    end

    // A same-cycle write resolves the hazard through the bypass.
    assign rbusy = !is_zero && pend[raddr] && !(hit_0 || hit_1);
endmodule

module register_file_mp #(
    parameter int DATA_W   = 16,
    parameter int N_REG    = 32,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(N_REG)
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     we_0,
    input  logic [ADDR_W-1:0]        waddr_0,
    input  logic [DATA_W-1:0]        wdata_0,
    input  logic                     we_1,
    input  logic [ADDR_W-1:0]        waddr_1,
    input  logic [DATA_W-1:0]        wdata_1,
    input  logic [N_RD*ADDR_W-1:0]   raddr,
    output logic [N_RD*DATA_W-1:0]   rdata,
    output logic [N_RD-1:0]          rbusy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          pend_cnt
);
    logic [N_REG-1:0][DATA_W-1:0] regs;
    logic [N_REG-1:0]             pend, pend_nxt;
    logic [ADDR_W:0]              cnt_nxt;
    logic                         wr0_ok, wr1_ok, rsv_ok;

    // Register 0 swallows writes and reservations when hard-wired to zero.
    assign wr0_ok = we_0   && !((ZERO_REG != 0) && (waddr_0  == '0));
    assign wr1_ok = we_1   && !((ZERO_REG != 0) && (waddr_1  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Lane 1 assignment comes last so it wins an address conflict.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            regs <= '0;
        end else begin
            if (wr0_ok) regs[waddr_0] <= wdata_0;
            if (wr1_ok) regs[waddr_1] <= wdata_1;
        end
    end

    // Scoreboard: a write retires the old producer, but a same-cycle
    // reservation belongs to a new producer, so set overrides clear.
    always_comb begin
        pend_nxt = pend;
        cnt_nxt  = '0;
        for (int i = 0; i < N_REG; i++) begin
            if ((we_0 && waddr_0 == ADDR_W'(i)) || (we_1 && waddr_1 == ADDR_W'(i)))
                pend_nxt[i] = 1'b0;
            if (rsv_ok && rsv_addr == ADDR_W'(i))
                pend_nxt[i] = 1'b1;
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : gen_rd
        register_file_mp_rd_port #(
            .DATA_W   (DATA_W),
            .N_REG    (N_REG),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .regs    (regs),
            .pend    (pend),
            .raddr   (raddr[k*ADDR_W +: ADDR_W]),
            .we_0    (we_0),
            .waddr_0 (waddr_0),
            .wdata_0 (wdata_0),
            .we_1    (we_1),
            .waddr_1 (waddr_1),
            .wdata_1 (wdata_1),
            .rdata   (rdata[k*DATA_W +: DATA_W]),
            .rbusy   (rbusy[k])
        );
    end
endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
    localparam int DATA_W = 16;
    localparam int N_REG  = 32;
    localparam int N_RD   = 2;
    localparam int ADDR_W = 5;

    logic                   clk = 1'b0;
    logic                   arst_n;
    logic                   we_0, we_1, rsv_en;
    logic [ADDR_W-1:0]      waddr_0, waddr_1, rsv_addr;
    logic [DATA_W-1:0]      wdata_0, wdata_1;
    logic [ADDR_W-1:0]      ra [N_RD];
    logic [N_RD*ADDR_W-1:0] raddr;
    logic [N_RD*DATA_W-1:0] rdata;
    logic [N_RD-1:0]        rbusy;
    logic [ADDR_W:0]        pend_cnt;

    assign raddr = {ra[1], ra[0]};

    register_file_mp #(.DATA_W(DATA_W), .N_REG(N_REG), .N_RD(N_RD), .ZERO_REG(1)) dut (
        .clk(clk), .arst_n(arst_n),
        .we_0(we_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
        .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays updated from the behavioural rules.
    logic [DATA_W-1:0] mreg  [N_REG];
    bit                mpend [N_REG];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_REG; i++) begin
            mreg[i]  = '0;
            mpend[i] = 1'b0;
        end
    endtask

    function automatic bit wr_hits(input int a);
        return (we_0 && int'(waddr_0) == a) || (we_1 && int'(waddr_1) == a);
    endfunction

    function automatic int exp_rdata(input int a);
        if (a == 0)                       return 0;
        if (we_1 && int'(waddr_1) == a)   return int'(wdata_1);
        if (we_0 && int'(waddr_0) == a)   return int'(wdata_0);
        return int'(mreg[a]);
    endfunction

    function automatic int exp_busy(input int a);
        return (a != 0 && mpend[a] && !wr_hits(a)) ? 1 : 0;
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < N_REG; i++) c += int'(mpend[i]);
        return c;
    endfunction

    task automatic model_update();
        bit nxt [N_REG];
        for (int i = 0; i < N_REG; i++) begin
            nxt[i] = mpend[i];
            if (wr_hits(i)) nxt[i] = 1'b0;
            if (rsv_en && int'(rsv_addr) == i && i != 0) nxt[i] = 1'b1;
        end
        if (we_0 && waddr_0 != 0) mreg[waddr_0] = wdata_0;
        if (we_1 && waddr_1 != 0) mreg[waddr_1] = wdata_1;
        for (int i = 0; i < N_REG; i++) mpend[i] = nxt[i];
    endtask

    task automatic drive(input logic w0, input int a0, input int d0,
                         input logic w1, input int a1, input int d1,
                         input logic rv, input int rva, input int r0, input int r1);
        we_0 = w0; waddr_0 = ADDR_W'(a0); wdata_0 = DATA_W'(d0);
        we_1 = w1; waddr_1 = ADDR_W'(a1); wdata_1 = DATA_W'(d1);
        rsv_en = rv; rsv_addr = ADDR_W'(rva);
        ra[0] = ADDR_W'(r0); ra[1] = ADDR_W'(r1);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N_RD; k++) begin
            chk({tag, "/rdata"}, int'(rdata[k*DATA_W +: DATA_W]), exp_rdata(int'(ra[k])));
            chk({tag, "/rbusy"}, int'(rbusy[k]), exp_busy(int'(ra[k])));
        end
        chk({tag, "/pend_cnt"}, int'(pend_cnt), exp_cnt());
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        arst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        model_reset();
        #2;
        check_all("reset");
        chk("reset_pend_cnt", int'(pend_cnt), 0);
        #1 arst_n = 1'b1;
        clock_edge();

        // Bypass from lane 0, then readback from the array.
        drive(1, 3, 'h1234, 0, 0, 0, 0, 0, 3, 0);
        #1 check_all("bypass0");
        chk("bypass0_const", int'(rdata[15:0]), 'h1234);
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1 check_all("array3");
        chk("array3_const", int'(rdata[15:0]), 'h1234);
        clock_edge();

        // Same-address conflict: lane 1 wins in bypass and in storage.
        drive(1, 7, 'hAAAA, 1, 7, 'h5555, 0, 0, 7, 7);
        #1 check_all("conflict");
        chk("conflict_const", int'(rdata[31:16]), 'h5555);
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        #1 chk("conflict_store", int'(rdata[15:0]), 'h5555);
        clock_edge();

        // Zero register ignores writes and reservations.
        drive(1, 0, 'hFFFF, 0, 0, 0, 1, 0, 0, 0);
        #1 check_all("zero_wr");
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_all("zero_rd");
        chk("zero_rdata", int'(rdata[15:0]), 0);
        chk("zero_pend", int'(pend_cnt), 0);
        clock_edge();

        // Reserve 9, then retire it through lane 1.
        drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        #1 check_all("rsv9");
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        #1 check_all("pend9");
        chk("pend9_busy", int'(rbusy[0]), 1);
        chk("pend9_cnt", int'(pend_cnt), 1);
        clock_edge();
        drive(0, 0, 0, 1, 9, 'h0042, 0, 0, 9, 0);
        #1 check_all("ret9");
        chk("ret9_busy", int'(rbusy[0]), 0);
        chk("ret9_rdata", int'(rdata[15:0]), 'h0042);
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        #1 chk("ret9_cnt", int'(pend_cnt), 0);
        clock_edge();

        // Reserve and write the same register: data lands, pending stays set.
        drive(1, 4, 'h0101, 0, 0, 0, 1, 4, 4, 0);
        #1 check_all("rsvwr4");
        clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        #1 check_all("rsvwr4_after");
        chk("rsvwr4_data", int'(rdata[15:0]), 'h0101);
        chk("rsvwr4_busy", int'(rbusy[0]), 1);
        chk("rsvwr4_cnt", int'(pend_cnt), 1);

        // Asynchronous reset between edges clears everything at once.
        #2 arst_n = 1'b0;
        model_reset();
        #1 chk("arst_cnt", int'(pend_cnt), 0);
        chk("arst_data", int'(rdata[15:0]), 0);
        chk("arst_busy", int'(rbusy[0]), 0);
        #1 arst_n = 1'b1;
        clock_edge();

        // Randomized traffic, addresses biased to a small window for collisions.
        for (int n = 0; n < 400; n++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? N_REG - 1 : 7;
            drive(logic'($urandom_range(0, 1)), int'($urandom_range(0, lim)), int'($urandom_range(0, 16'hFFFF)),
                  logic'($urandom_range(0, 1)), int'($urandom_range(0, lim)), int'($urandom_range(0, 16'hFFFF)),
                  logic'($urandom_range(0, 2) == 0), int'($urandom_range(0, lim)),
                  int'($urandom_range(0, lim)), int'($urandom_range(0, lim)));
            #1 check_all("rand");
            clock_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
